// File: rtl/sfq_xor_tx_if.sv
// Word handshake from the harness plus the toggle-encoded lines driven into the SFQ cell.
interface sfq_xor_tx_if;
   logic        in_valid;
   logic        in_a;
   logic        in_b;
   logic        in_ready;
   logic        a_out;
   logic        b_out;
   logic        clk_out;
   logic        exp_out;
   logic [15:0] pulse_cnt;

   modport slave (
      input  in_valid, in_a, in_b,
      output in_ready, a_out, b_out, clk_out, exp_out, pulse_cnt
   );

   modport master (
      output in_valid, in_a, in_b,
      input  in_ready, a_out, b_out, clk_out, exp_out, pulse_cnt
   );
endinterface

// File: rtl/sfq_xor_tx.sv
// Turns 2-bit words into spaced level toggles on the a/b/clk lines of a clocked SFQ cell, plus the expected result.
// First toggle one cycle after accept; in_ready stays low for the whole word, so a pending word waits at the source.
module sfq_xor_tx #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned HOLD_CYC   = 3,
   parameter int unsigned AB_GAP_CYC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   sfq_xor_tx_if.slave io
);
   typedef enum logic [2:0] {IDLE, DATA_A, GAP_AB, DATA_B, SETUP, FIRE, HOLD} state_t;

   // Timer loads give the number of extra cycles spent in the state; it exits when the timer is zero.
   // A zero word has no data cycle, so its SETUP stretch is one cycle longer.
   localparam logic [3:0] GAP_LD   = (AB_GAP_CYC > 1) ? 4'(AB_GAP_CYC - 2) : 4'd0;
   localparam logic [3:0] SET_LD   = (SETUP_CYC > 1)  ? 4'(SETUP_CYC - 2)  : 4'd0;
   localparam logic [3:0] SET0_LD  = (SETUP_CYC > 0)  ? 4'(SETUP_CYC - 1)  : 4'd0;
   localparam logic [3:0] HOLD_LD  = (HOLD_CYC > 0)   ? 4'(HOLD_CYC - 1)   : 4'd0;
   localparam bit         GAP_EN   = (AB_GAP_CYC > 1);
   localparam bit         SET_EN   = (SETUP_CYC > 1);
   localparam bit         HOLD_EN  = (HOLD_CYC > 0);

   state_t      state_q, state_d;
   logic [3:0]  tmr_q, tmr_d;
   logic        lat_a_q, lat_a_d;
   logic        lat_b_q, lat_b_d;
   logic        a_q, a_d;
   logic        b_q, b_d;
   logic        c_q, c_d;
   logic        x_q, x_d;
   logic [15:0] cnt_q, cnt_d;
   logic        rdy_q;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      lat_a_d = lat_a_q;
      lat_b_d = lat_b_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               lat_a_d = io.in_a;
               lat_b_d = io.in_b;
               if (io.in_a) begin
                  state_d = DATA_A;
               end else if (io.in_b) begin
                  state_d = DATA_B;
               end else begin
                  state_d = SETUP;
                  tmr_d   = SET0_LD;
               end
            end
         end
         DATA_A: begin
            a_d = ~a_q;
            if (lat_b_q) begin
               if (GAP_EN) begin
                  state_d = GAP_AB;
                  tmr_d   = GAP_LD;
               end else begin
                  state_d = DATA_B;
               end
            end else if (SET_EN) begin
               state_d = SETUP;
               tmr_d   = SET_LD;
            end else begin
               state_d = FIRE;
            end
         end
         GAP_AB: begin
            if (tmr_q == 4'd0) state_d = DATA_B;
            else               tmr_d   = tmr_q - 4'd1;
         end
         DATA_B: begin
            b_d = ~b_q;
            if (SET_EN) begin
               state_d = SETUP;
               tmr_d   = SET_LD;
            end else begin
               state_d = FIRE;
            end
         end
         SETUP: begin
            if (tmr_q == 4'd0) state_d = FIRE;
            else               tmr_d   = tmr_q - 4'd1;
         end
         FIRE: begin
            c_d   = ~c_q;
            x_d   = x_q ^ (lat_a_q ^ lat_b_q);
            cnt_d = cnt_q + 16'd1;
            if (HOLD_EN) begin
               state_d = HOLD;
               tmr_d   = HOLD_LD;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (tmr_q == 4'd0) state_d = IDLE;
            else               tmr_d   = tmr_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tmr_q   <= 4'd0;
         lat_a_q <= 1'b0;
         lat_b_q <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         c_q     <= 1'b0;
         x_q     <= 1'b0;
         cnt_q   <= 16'd0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         lat_a_q <= lat_a_d;
         lat_b_q <= lat_b_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         rdy_q   <= (state_d == IDLE);
      end
   end

   assign io.in_ready  = rdy_q;
   assign io.a_out     = a_q;
   assign io.b_out     = b_q;
   assign io.clk_out   = c_q;
   assign io.exp_out   = x_q;
   assign io.pulse_cnt = cnt_q;
endmodule

// File: tb/tb_sfq_xor_tx.sv
// Bench for sfq_xor_tx: event-schedule model of two instances compared every cycle, plus hand-computed edge checks.
module tb_sfq_xor_tx;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sfq_xor_tx_if if0 ();
   sfq_xor_tx_if if1 ();

   sfq_xor_tx u_dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
   sfq_xor_tx #(.SETUP_CYC(2), .HOLD_CYC(0), .AB_GAP_CYC(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

   int n_chk = 0;
   int n_err = 0;
   int E = 0;

   // Timing parameters of each instance, as seen by the model.
   int p_s [2] = '{2, 2};
   int p_h [2] = '{3, 0};
   int p_g [2] = '{1, 2};

   int          t_a [2], t_b [2], t_c [2], t_r [2];
   logic        m_a [2], m_b [2], m_c [2], m_x [2], m_r [2], m_xor [2];
   logic [15:0] m_cnt [2];

   logic [1:0]  vld, ia, ib, o_a, o_b, o_c, o_x, o_r;
   logic [15:0] o_cnt [2];
   assign vld = {if1.in_valid, if0.in_valid};
   assign ia  = {if1.in_a, if0.in_a};
   assign ib  = {if1.in_b, if0.in_b};
   assign o_a = {if1.a_out, if0.a_out};
   assign o_b = {if1.b_out, if0.b_out};
   assign o_c = {if1.clk_out, if0.clk_out};
   assign o_x = {if1.exp_out, if0.exp_out};
   assign o_r = {if1.in_ready, if0.in_ready};
   assign o_cnt[0] = if0.pulse_cnt;
   assign o_cnt[1] = if1.pulse_cnt;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         t_a[i] = -1; t_b[i] = -1; t_c[i] = -1; t_r[i] = -1;
         m_a[i] = 1'b0; m_b[i] = 1'b0; m_c[i] = 1'b0; m_x[i] = 1'b0;
         m_r[i] = 1'b1; m_xor[i] = 1'b0; m_cnt[i] = 16'd0;
      end
   endtask

   // Each accepted word becomes a list of absolute edge numbers at which each line must toggle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         E = E + 1;
         for (int i = 0; i < 2; i++) begin
            logic acc;
            int   last;
            acc = vld[i] && m_r[i];
            if (t_a[i] == E) m_a[i] = ~m_a[i];
            if (t_b[i] == E) m_b[i] = ~m_b[i];
            if (t_c[i] == E) begin
               m_c[i]   = ~m_c[i];
               m_cnt[i] = m_cnt[i] + 16'd1;
               if (m_xor[i]) m_x[i] = ~m_x[i];
            end
            if (t_r[i] == E) m_r[i] = 1'b1;
            if (acc) begin
               t_a[i] = ia[i] ? E + 1 : -1;
               if (ia[i] && ib[i]) t_b[i] = E + 1 + p_g[i];
               else if (ib[i])     t_b[i] = E + 1;
               else                t_b[i] = -1;
               last     = (t_b[i] > 0) ? t_b[i] : E + 1;
               t_c[i]   = last + p_s[i];
               t_r[i]   = t_c[i] + p_h[i];
               m_r[i]   = 1'b0;
               m_xor[i] = ia[i] ^ ib[i];
            end
         end
      end
   end

   task automatic chk1(string name, logic act, logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b (edge %0d)", name, act, exp, E);
      end
   endtask

   task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, E);
      end
   endtask

   task automatic chki(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk1($sformatf("model%0d.a_out", i), o_a[i], m_a[i]);
         chk1($sformatf("model%0d.b_out", i), o_b[i], m_b[i]);
         chk1($sformatf("model%0d.clk_out", i), o_c[i], m_c[i]);
         chk1($sformatf("model%0d.exp_out", i), o_x[i], m_x[i]);
         chk1($sformatf("model%0d.in_ready", i), o_r[i], m_r[i]);
         chk16($sformatf("model%0d.pulse_cnt", i), o_cnt[i], m_cnt[i]);
      end
   end

   task automatic drive(int idx, logic v, logic a, logic b);
      if (idx == 0) begin
         if0.in_valid = v; if0.in_a = a; if0.in_b = b;
      end else begin
         if1.in_valid = v; if1.in_a = a; if1.in_b = b;
      end
   endtask

   function automatic logic rdy(int idx);
      return (idx == 0) ? if0.in_ready : if1.in_ready;
   endfunction

   task automatic at_edge(int n);
      for (int k = 0; k < 2000 && E < n; k++) begin
         @(posedge clk);
         #1;
      end
      chki("at_edge", E, n);
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(int idx, logic a, logic b, bit drop);
      drive(idx, 1'b1, a, b);
      for (int k = 0; k < 100 && !rdy(idx); k++) @(negedge clk);
      chk1("send_ready", rdy(idx), 1'b1);
      @(negedge clk);
      if (drop) drive(idx, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int A;
      int B;
      model_reset();
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      chk1("rst.in_ready0", if0.in_ready, 1'b1);
      chk1("rst.a_out0", if0.a_out, 1'b0);
      chk1("rst.clk_out0", if0.clk_out, 1'b0);
      chk16("rst.pulse_cnt0", if0.pulse_cnt, 16'd0);
      chk1("rst.in_ready1", if1.in_ready, 1'b1);
      #2 rst_n = 1'b1;

      // {1,0} on the default instance and {1,1} with AB gap 2 on the other, both accepted at edge 5.
      at_edge(4);
      drive(0, 1'b1, 1'b1, 1'b0);
      drive(1, 1'b1, 1'b1, 1'b1);
      at_edge(5);
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      chk1("t1.in_ready_low0", if0.in_ready, 1'b0);
      chk1("t1.in_ready_low1", if1.in_ready, 1'b0);
      at_edge(6);
      chk1("t1.a_out0@6", if0.a_out, 1'b1);
      chk1("t1.clk_out0@6", if0.clk_out, 1'b0);
      chk1("t2.a_out1@6", if1.a_out, 1'b1);
      chk1("t2.b_out1@6", if1.b_out, 1'b0);
      at_edge(7);
      chk1("t1.clk_out0@7", if0.clk_out, 1'b0);
      chk1("t2.b_out1@7", if1.b_out, 1'b0);
      at_edge(8);
      chk1("t1.clk_out0@8", if0.clk_out, 1'b1);
      chk1("t1.exp_out0@8", if0.exp_out, 1'b1);
      chk16("t1.pulse_cnt0@8", if0.pulse_cnt, 16'd1);
      chk1("t2.b_out1@8", if1.b_out, 1'b1);
      chk1("t2.clk_out1@8", if1.clk_out, 1'b0);
      at_edge(9);
      chk1("t2.clk_out1@9", if1.clk_out, 1'b0);
      at_edge(10);
      chk1("t1.in_ready0@10", if0.in_ready, 1'b0);
      chk1("t2.clk_out1@10", if1.clk_out, 1'b1);
      chk1("t2.exp_out1@10", if1.exp_out, 1'b0);
      chk1("t2.in_ready1@10", if1.in_ready, 1'b1);
      at_edge(11);
      chk1("t1.in_ready0@11", if0.in_ready, 1'b1);

      // Reset pulsed while word {1,0} sits in SETUP.
      send(0, 1'b1, 1'b0, 1'b1);
      at_edge(13);
      #2 rst_n = 1'b0;
      #1;
      chk1("t5.a_out0", if0.a_out, 1'b0);
      chk1("t5.exp_out0", if0.exp_out, 1'b0);
      chk16("t5.pulse_cnt0", if0.pulse_cnt, 16'd0);
      chk1("t5.in_ready0", if0.in_ready, 1'b1);
      chk1("t5.b_out1", if1.b_out, 1'b0);
      chk1("t5.clk_out1", if1.clk_out, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk1("t5.clk_out0_held", if0.clk_out, 1'b0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk1("t5.in_ready0_after", if0.in_ready, 1'b1);
      chk16("t5.pulse_cnt0_after", if0.pulse_cnt, 16'd0);

      // Back-to-back {0,1},{1,0},{0,0} with in_valid held high.
      A = E + 1;
      send(0, 1'b0, 1'b1, 1'b0);
      chki("t3.accept0", E, A);
      at_edge(A + 3);
      chk1("t3.exp_out@A+3", if0.exp_out, 1'b1);
      chk1("t3.clk_out@A+3", if0.clk_out, 1'b1);
      send(0, 1'b1, 1'b0, 1'b0);
      chki("t3.accept1", E, A + 7);
      at_edge(A + 10);
      chk1("t3.exp_out@A+10", if0.exp_out, 1'b0);
      send(0, 1'b0, 1'b0, 1'b0);
      chki("t3.accept2", E, A + 14);
      at_edge(A + 17);
      chk16("t3.pulse_cnt", if0.pulse_cnt, 16'd3);
      chk1("t3.exp_out_end", if0.exp_out, 1'b0);
      chk1("t3.clk_out_end", if0.clk_out, 1'b1);

      // Changing data with in_valid high while busy; only the value seen in IDLE is taken.
      drive(0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (if0.in_ready) break;
         drive(0, 1'b1, k[0], 1'b1);
      end
      drive(0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0);
      chki("t4.accept", E, A + 21);
      at_edge(A + 22);
      chk1("t4.a_out", if0.a_out, 1'b0);
      chk1("t4.b_out", if0.b_out, 1'b1);
      at_edge(A + 24);
      chk1("t4.clk_out", if0.clk_out, 1'b0);
      chk1("t4.exp_out", if0.exp_out, 1'b1);
      chk16("t4.pulse_cnt", if0.pulse_cnt, 16'd4);

      // Pulse counter wrap on the HOLD_CYC=0 instance.
      @(posedge clk);
      #2;
      force u_dut1.cnt_q = 16'hFFFF;
      m_cnt[1] = 16'hFFFF;
      #1;
      release u_dut1.cnt_q;
      @(negedge clk);
      chk16("t6.pulse_cnt_pre", if1.pulse_cnt, 16'hFFFF);
      B = E + 1;
      send(1, 1'b0, 1'b0, 1'b1);
      chki("t6.accept", E, B);
      at_edge(B + 3);
      chk16("t6.pulse_cnt_wrap", if1.pulse_cnt, 16'h0000);
      chk1("t6.clk_out", if1.clk_out, 1'b1);
      chk1("t6.exp_out", if1.exp_out, 1'b0);
      chk1("t6.in_ready", if1.in_ready, 1'b1);
      at_edge(B + 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
